cmd_list_axi_writer: RTL and testbench



---
 rtl/cmd_list_axi_writer_if.sv | 36 +++
 rtl/cmd_list_axi_writer.sv | 247 ++++++++++++++++++++++++
 tb/tb_cmd_list_axi_writer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_list_axi_writer_if.sv
// AXI4-Lite write-only bus between the command list writer (master) and the
// Accelerator slave port: AW, W and B channels.
interface cmd_list_axi_writer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0]   oAWADDR;
    logic [2:0]              oAWPROT;
    logic                    oAWVALID;
    logic                    iAWREADY;

    logic [DATA_WIDTH-1:0]   oWDATA;
    logic [DATA_WIDTH/8-1:0] oWSTRB;
    logic                    oWVALID;
    logic                    iWREADY;

    logic                    oBREADY;
    logic [1:0]              iBRESP;
    logic                    iBVALID;

    modport master (
        output oAWADDR, oAWPROT, oAWVALID,
        output oWDATA, oWSTRB, oWVALID,
        output oBREADY,
        input  iAWREADY, iWREADY, iBRESP, iBVALID
    );

    modport slave (
        input  oAWADDR, oAWPROT, oAWVALID,
        input  oWDATA, oWSTRB, oWVALID,
        input  oBREADY,
        output iAWREADY, iWREADY, iBRESP, iBVALID
    );

endinterface

// File: rtl/cmd_list_axi_writer.sv
// Command list AXI4-Lite write master.
// The host fills a small command buffer while the block is idle, then a start
// replays list_len entries as single-beat writes to a fixed target address.
// AW and W are handshaked independently; the B response closes each beat.
// Playback can loop, is halted by the Accelerator's RenderEndInterrupt at the
// next B handshake, and BRESP errors are flagged and counted.
module cmd_list_axi_writer #(
    parameter int         DATA_WIDTH = 8,
    parameter int         ADDR_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter int         IDXW       = $clog2(DEPTH),
    parameter logic [2:0] AWPROT_VAL = 3'b010
) (
    input  logic                  clk,
    input  logic                  nreset,

    input  logic                  load_we,
    input  logic [IDXW-1:0]       load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,

    input  logic [IDXW:0]         list_len,
    input  logic [ADDR_WIDTH-1:0] target_addr,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  stop_irq,

    cmd_list_axi_writer_if.master axi,

    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            err_count,
    output logic [15:0]           sent_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        FIN
    } state_t;

    localparam logic [IDXW:0] DEPTH_L = (IDXW+1)'(DEPTH);

    state_t                  state_q,   state_d;
    logic [IDXW:0]           len_q,     len_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic                    loop_q,    loop_d;
    logic [IDXW-1:0]         idx_q,     idx_d;

    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    awacc_q,   awacc_d;
    logic                    wacc_q,    wacc_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic                    bready_q,  bready_d;

    logic                    stop_q,    stop_d;
    logic                    err_q,     err_d;
    logic [7:0]              errcnt_q,  errcnt_d;
    logic [15:0]             sent_q,    sent_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    load_ok;
    logic [IDXW:0]           len_clamped;
    logic [DATA_WIDTH-1:0]   first_data;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    aw_all;
    logic                    w_all;
    logic                    last_entry;
    logic [IDXW-1:0]         idx_next;

    assign load_ok     = load_we && (state_q == IDLE);
    assign len_clamped = (list_len > DEPTH_L) ? DEPTH_L : list_len;
    assign first_data  = (load_ok && (load_addr == '0)) ? load_data : mem_q[0];

    assign aw_hs       = awvalid_q & axi.iAWREADY;
    assign w_hs        = wvalid_q  & axi.iWREADY;
    assign b_hs        = bready_q  & axi.iBVALID;
    assign aw_all      = awacc_q | aw_hs;
    assign w_all       = wacc_q  | w_hs;

    assign last_entry  = ({1'b0, idx_q} == (len_q - 1'b1));
    assign idx_next    = last_entry ? '0 : (idx_q + 1'b1);

    // Host command buffer: written only while idle, never reset, read by index.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // State and datapath registers; reset drops every valid immediately.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            loop_q    <= 1'b0;
            idx_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awacc_q   <= 1'b0;
            wacc_q    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
            stop_q    <= 1'b0;
            err_q     <= 1'b0;
            errcnt_q  <= '0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            loop_q    <= loop_d;
            idx_q     <= idx_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awacc_q   <= awacc_d;
            wacc_q    <= wacc_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bready_q  <= bready_d;
            stop_q    <= stop_d;
            err_q     <= err_d;
            errcnt_q  <= errcnt_d;
            sent_q    <= sent_d;
        end
    end

    // Playback sequencing: launch a beat, collect AW/W accepts, close on B.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        loop_d    = loop_q;
        idx_d     = idx_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awacc_d   = awacc_q;
        wacc_d    = wacc_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bready_d  = bready_q;
        stop_d    = stop_q;
        err_d     = err_q;
        errcnt_d  = errcnt_q;
        sent_d    = sent_q;

        case (state_q)
            IDLE: begin
                if (start && (list_len != '0)) begin
                    state_d   = ISSUE;
                    len_d     = len_clamped;
                    addr_d    = target_addr;
                    loop_d    = loop_en;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    errcnt_d  = '0;
                    sent_d    = '0;
                    stop_d    = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awacc_d   = 1'b0;
                    wacc_d    = 1'b0;
                    awaddr_d  = target_addr;
                    wdata_d   = first_data;
                end
            end

            ISSUE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    awacc_d   = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    wacc_d   = 1'b1;
                end
                if (aw_all && w_all) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                end
            end

            RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    sent_d   = sent_q + 16'd1;
                    if (axi.iBRESP != 2'b00) begin
                        err_d = 1'b1;
                        if (errcnt_q != 8'hFF) begin
                            errcnt_d = errcnt_q + 8'd1;
                        end
                    end
                    if (stop_q || stop_irq || (last_entry && !loop_q)) begin
                        state_d = FIN;
                    end else begin
                        state_d   = ISSUE;
                        idx_d     = idx_next;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awacc_d   = 1'b0;
                        wacc_d    = 1'b0;
                        awaddr_d  = addr_q;
                        wdata_d   = mem_q[idx_next];
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop_irq && ((state_q == ISSUE) || (state_q == RESP))) begin
            stop_d = 1'b1;
        end
        if (state_q == FIN) begin
            stop_d = 1'b0;
        end
    end

    assign axi.oAWADDR  = awaddr_q;
    assign axi.oAWPROT  = AWPROT_VAL;
    assign axi.oAWVALID = awvalid_q;
    assign axi.oWDATA   = wdata_q;
    assign axi.oWSTRB   = wvalid_q ? '1 : '0;
    assign axi.oWVALID  = wvalid_q;
    assign axi.oBREADY  = bready_q;

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign err        = err_q;
    assign err_count  = errcnt_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_cmd_list_axi_writer.sv
// Randomised bench for cmd_list_axi_writer: a slave model with random readies,
// B latency and error responses, a stimulus process issuing runs, and a
// monitor comparing every AW/W/B handshake and run end against a queue of
// expected beats derived from the buffer contents and the playback rules.
module tb_cmd_list_axi_writer;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int IDXW  = 4;

    logic            clk;
    logic            nreset;
    logic            load_we;
    logic [IDXW-1:0] load_addr;
    logic [DW-1:0]   load_data;
    logic [IDXW:0]   list_len;
    logic [AW-1:0]   target_addr;
    logic            loop_en;
    logic            start;
    logic            stop_irq;
    logic            busy;
    logic            done;
    logic            err;
    logic [7:0]      err_count;
    logic [15:0]     sent_count;

    cmd_list_axi_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    cmd_list_axi_writer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .list_len(list_len),
        .target_addr(target_addr),
        .loop_en(loop_en),
        .start(start),
        .stop_irq(stop_irq),
        .axi(bus),
        .busy(busy),
        .done(done),
        .err(err),
        .err_count(err_count),
        .sent_count(sent_count)
    );

    int            vectors;
    int            miscompares;

    logic [DW-1:0] modelBuf [DEPTH];
    logic [DW-1:0] expQ [$];
    bit            runActive;
    bit            runLoop;
    int            runLen;
    logic [AW-1:0] runAddr;
    int            runBeats;
    int            runErrs;
    bit            stopPend;
    bit            expectDoneNow;
    bit            expectDoneNext;
    bit            expectIdleNow;
    int            awCnt;
    int            wCnt;
    bit            awWait;
    bit            wWait;
    logic [AW-1:0] awWaitAddr;
    logic [DW-1:0] wWaitData;

    int            rdyPct;
    int            errPct;
    int            bDelayMax;

    bit            awSeen;
    bit            wSeen;
    bit            bHs;
    int            bDelay;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name, input string why);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: %s (t=%0t)", name, why, $time);
    endtask

    task automatic finishBench();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Slave responder: random readies, B issued after both AW and W accepted.
    initial begin
        bus.iAWREADY = 1'b0;
        bus.iWREADY  = 1'b0;
        bus.iBVALID  = 1'b0;
        bus.iBRESP   = 2'b00;
        awSeen = 0; wSeen = 0; bHs = 0; bDelay = 0;
        forever begin
            @(negedge clk);
            if (nreset) begin
                bus.iAWREADY = 1'b0;
                bus.iWREADY  = 1'b0;
                bus.iBVALID  = 1'b0;
                awSeen = 0; wSeen = 0; bHs = 0;
            end else begin
                if (bHs) begin
                    bus.iBVALID = 1'b0;
                    bHs = 0;
                end
                if (awSeen && wSeen && !bus.iBVALID) begin
                    if (bDelay == 0) begin
                        bus.iBVALID = 1'b1;
                        bus.iBRESP  = ($urandom_range(0, 99) < errPct) ? 2'b10 : 2'b00;
                        awSeen = 0;
                        wSeen  = 0;
                    end else begin
                        bDelay--;
                    end
                end
                bus.iAWREADY = ($urandom_range(0, 99) < rdyPct);
                bus.iWREADY  = ($urandom_range(0, 99) < rdyPct);
                #1;
                if (!(awSeen && wSeen)) begin
                    if (bus.oAWVALID && bus.iAWREADY) awSeen = 1;
                    if (bus.oWVALID && bus.iWREADY) wSeen = 1;
                    if (awSeen && wSeen) bDelay = $urandom_range(0, bDelayMax);
                end
                if (bus.iBVALID && bus.oBREADY) bHs = 1;
            end
        end
    end

    // Monitor: compares every handshake and run end against the scoreboard.
    initial begin
        logic [DW-1:0] e;
        bit inFin;
        forever begin
            @(negedge clk);
            #1;
            if (nreset) begin
                awWait = 0; wWait = 0;
                expectDoneNow = 0; expectDoneNext = 0; expectIdleNow = 0;
                awCnt = 0; wCnt = 0;
            end else begin
                inFin = expectDoneNow;
                if (awWait) checkOutput("aw_hold", 32'({bus.oAWVALID, bus.oAWADDR}), 32'({1'b1, awWaitAddr}));
                if (wWait)  checkOutput("w_hold",  32'({bus.oWVALID, bus.oWDATA}),  32'({1'b1, wWaitData}));

                if (expectDoneNow) begin
                    checkOutput("done_pulse", 32'(done), 32'd1);
                    checkOutput("sent_count", 32'(sent_count), 32'(runBeats % 65536));
                    checkOutput("err_flag", 32'(err), 32'(runErrs != 0));
                    checkOutput("err_count", 32'(err_count), 32'((runErrs > 255) ? 255 : runErrs));
                    runActive = 0;
                    stopPend = 0;
                    expQ.delete();
                    expectIdleNow = 1;
                    expectDoneNow = 0;
                end else begin
                    if (expectIdleNow) begin
                        checkOutput("busy_after_done", 32'(busy), 32'd0);
                        expectIdleNow = 0;
                    end
                    if (done) checkOutput("done_unexpected", 32'(done), 32'd0);
                end

                if (!runActive && (bus.oAWVALID || bus.oWVALID)) failNow("valid_while_idle", "valid raised outside a run");

                if (bus.oAWVALID && bus.iAWREADY) begin
                    checkOutput("awaddr", 32'(bus.oAWADDR), 32'(runAddr));
                    checkOutput("awprot", 32'(bus.oAWPROT), 32'(3'b010));
                    awCnt++;
                end
                if (bus.oWVALID && bus.iWREADY) begin
                    if (expQ.size() == 0) begin
                        failNow("w_extra", "W handshake with no expected beat");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("wdata", 32'(bus.oWDATA), 32'(e));
                    end
                    checkOutput("wstrb", 32'(bus.oWSTRB), 32'd1);
                    wCnt++;
                end
                if (!bus.oWVALID) checkOutput("wstrb_idle", 32'(bus.oWSTRB), 32'd0);

                awWait = bus.oAWVALID && !bus.iAWREADY;
                awWaitAddr = bus.oAWADDR;
                wWait = bus.oWVALID && !bus.iWREADY;
                wWaitData = bus.oWDATA;

                if (runActive && stop_irq && !inFin) stopPend = 1;

                if (bus.iBVALID && bus.oBREADY) begin
                    checkOutput("beat_aw_count", 32'(awCnt), 32'd1);
                    checkOutput("beat_w_count", 32'(wCnt), 32'd1);
                    awCnt = 0;
                    wCnt = 0;
                    runBeats++;
                    if (bus.iBRESP != 2'b00) runErrs++;
                    if (stopPend || (!runLoop && (runBeats == runLen))) expectDoneNext = 1;
                end
                expectDoneNow = expectDoneNext;
                expectDoneNext = 0;
            end
        end
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #500000;
        failNow("watchdog", "simulation time limit reached");
        finishBench();
    end

    task automatic loadEntry(input int idx, input logic [DW-1:0] data);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = IDXW'(idx);
        load_data = data;
        modelBuf[idx] = data;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input logic [AW-1:0] addr, input bit loop,
                                 input int stopAt, input bit loadWithStart);
        int effLen;
        int n;
        int cycles;
        effLen = (len > DEPTH) ? DEPTH : len;
        @(negedge clk);
        list_len    = (IDXW+1)'(len);
        target_addr = addr;
        loop_en     = loop;
        start       = 1'b1;
        if (loadWithStart) begin
            load_we   = 1'b1;
            load_addr = '0;
            load_data = DW'($urandom);
            modelBuf[0] = load_data;
        end
        if (effLen == 0) begin
            @(negedge clk);
            start   = 1'b0;
            load_we = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            checkOutput("len0_idle", 32'(busy), 32'd0);
            return;
        end
        runActive = 1;
        runLen    = effLen;
        runLoop   = loop;
        runAddr   = addr;
        runBeats  = 0;
        runErrs   = 0;
        stopPend  = 0;
        expQ.delete();
        n = loop ? 64 : effLen;
        for (int k = 0; k < n; k++) expQ.push_back(modelBuf[k % effLen]);

        @(negedge clk);
        start     = 1'b0;
        load_we   = 1'b1;
        load_addr = IDXW'($urandom);
        load_data = ~modelBuf[load_addr];
        #1;
        checkOutput("first_valid", 32'({bus.oAWVALID, bus.oWVALID}), 32'(2'b11));
        checkOutput("start_clears", 32'({err, err_count, sent_count}), 32'd0);
        cycles = 1;
        while (runActive && (cycles < 2000)) begin
            @(negedge clk);
            cycles++;
            load_we  = 1'b0;
            stop_irq = (cycles == stopAt);
        end
        stop_irq = 1'b0;
        if (runActive) begin
            failNow("run_timeout", "run did not complete within 2000 cycles");
            finishBench();
        end
    endtask

    // Directed scenarios followed by randomised runs.
    initial begin
        vectors = 0; miscompares = 0;
        runActive = 0; stopPend = 0; runBeats = 0; runErrs = 0; runLen = 0; runLoop = 0; runAddr = '0;
        rdyPct = 100; errPct = 0; bDelayMax = 0;
        nreset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; list_len = '0;
        target_addr = '0; loop_en = 1'b0; start = 1'b0; stop_irq = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valids", 32'({bus.oAWVALID, bus.oWVALID, bus.oBREADY}), 32'd0);
        checkOutput("rst_status", 32'({busy, done, err}), 32'd0);
        checkOutput("rst_counts", 32'({err_count, sent_count}), 32'd0);
        checkOutput("rst_payload", 32'({bus.oAWADDR, bus.oWDATA, bus.oWSTRB}), 32'd0);
        @(negedge clk);
        nreset = 1'b0;

        for (int i = 0; i < DEPTH; i++) loadEntry(i, DW'($urandom));

        $display("[TB] one-shot run of three entries");
        loadEntry(0, 8'h50);
        loadEntry(1, 8'h50);
        loadEntry(2, 8'h07);
        applyStimulus(3, 8'h01, 1'b0, 0, 1'b0);

        $display("[TB] error responses then clearing start");
        errPct = 50; rdyPct = 70; bDelayMax = 2;
        applyStimulus(4, 8'h22, 1'b0, 0, 1'b0);
        errPct = 0;
        applyStimulus(2, 8'h33, 1'b0, 0, 1'b0);

        $display("[TB] looping run halted by stop_irq");
        rdyPct = 50;
        applyStimulus(2, 8'h44, 1'b1, 9, 1'b0);

        $display("[TB] zero length and clamped length");
        applyStimulus(0, 8'h55, 1'b0, 0, 1'b0);
        rdyPct = 100; bDelayMax = 0;
        applyStimulus(DEPTH + 5, 8'h66, 1'b0, 0, 1'b1);

        $display("[TB] randomised runs");
        for (int r = 0; r < 24; r++) begin
            int  len;
            bit  lp;
            int  stopAt;
            if ($urandom_range(0, 2) == 0) loadEntry($urandom_range(0, DEPTH - 1), DW'($urandom));
            len       = $urandom_range(1, DEPTH + 3);
            lp        = ($urandom_range(0, 2) == 0);
            stopAt    = lp ? $urandom_range(2, 60) : (($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : 0);
            rdyPct    = $urandom_range(30, 100);
            errPct    = $urandom_range(0, 50);
            bDelayMax = $urandom_range(0, 3);
            applyStimulus(len, AW'($urandom), lp, stopAt, $urandom_range(0, 1) == 1);
        end

        $display("[TB] reset during an outstanding write");
        rdyPct = 0; errPct = 0; bDelayMax = 0;
        @(negedge clk);
        list_len = 5'd3; target_addr = 8'h77; loop_en = 1'b0; start = 1'b1;
        runActive = 1; runLen = 3; runLoop = 0; runAddr = 8'h77; runBeats = 0; runErrs = 0;
        expQ.delete();
        for (int k = 0; k < 3; k++) expQ.push_back(modelBuf[k]);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("pre_reset_awvalid", 32'(bus.oAWVALID), 32'd1);
        #2;
        nreset = 1'b1;
        #1;
        checkOutput("async_rst_valids", 32'({bus.oAWVALID, bus.oWVALID, bus.oBREADY}), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        runActive = 0;
        expQ.delete();
        repeat (2) @(negedge clk);
        nreset = 1'b0;
        rdyPct = 100;
        applyStimulus(4, 8'h88, 1'b0, 0, 1'b0);

        repeat (3) @(negedge clk);
        finishBench();
    end

endmodule
